// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_feeder
// Description : Parallel-to-serial feeder, MSB-first, variable word length,
//               valid/ready on both sides with zero-bubble back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_feeder #(
    parameter int W  = 16,
    parameter int LW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [LW-1:0] in_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_first,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LW-1:0] C_W_LEN = LW'(W);
    localparam logic [LW-1:0] C_ONE   = LW'(1);

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_shift, w_shift_nxt;
    logic [LW-1:0] r_cnt,   w_cnt_nxt;
    logic [LW-1:0] r_len,   w_len_nxt;

    logic [LW-1:0] w_eff_len;
    logic [W-1:0]  w_load_data;
    logic          w_accept;
    logic          w_xfer;

    // A zero or oversize length means a full-width word.
    assign w_eff_len   = ((in_len == '0) || (in_len > C_W_LEN)) ? C_W_LEN : in_len;
    assign w_load_data = in_data << (C_W_LEN - w_eff_len);

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;

    // Outputs are forced low while rst is high, even before the state register clears.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            if (r_state == IDLE) begin
                in_ready = 1'b1;
            end else begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = r_shift[W-1];
                out_first = (r_cnt == r_len);
                out_last  = (r_cnt == C_ONE);
                in_ready  = (r_cnt == C_ONE) && out_ready;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = w_load_data;
                    w_cnt_nxt   = w_eff_len;
                    w_len_nxt   = w_eff_len;
                end
            end
            SHIFT: begin
                if (w_xfer) begin
                    if (r_cnt == C_ONE) begin
                        if (w_accept) begin
                            w_shift_nxt = w_load_data;
                            w_cnt_nxt   = w_eff_len;
                            w_len_nxt   = w_eff_len;
                        end else begin
                            w_state_nxt = IDLE;
                            w_shift_nxt = '0;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_shift_nxt = {r_shift[W-2:0], 1'b0};
                        w_cnt_nxt   = r_cnt - C_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bit_feeder
// Description : Self-checking bench: directed vector table, hand sequences,
//               and a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bit_feeder;

    localparam int W  = 16;
    localparam int LW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_len;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          out_first;
    logic          out_last;
    logic          busy;

    serial_bit_feeder #(.W(W), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  data;
        logic [LW-1:0] len;
        int            n;
        logic [W-1:0]  exp;   // expected bits in send order, left-aligned
    } vec_t;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } ebit_t;

    vec_t  vecs[7];
    ebit_t q[$];
    int    wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_bit"},   out_bit,   0);
        chk({nm, "_first"}, out_first, 0);
        chk({nm, "_last"},  out_last,  0);
        chk({nm, "_busy"},  busy,      0);
        chk({nm, "_rdy"},   in_ready,  0);
    endtask

    task automatic send_vec(input vec_t v);
        in_valid  = 1'b1;
        in_data   = v.data;
        in_len    = v.len;
        out_ready = 1'b1;
        #1;
        chk("idle_rdy",  in_ready, 1);
        chk("idle_busy", busy,     0);
        tick;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_len   = 5'($urandom);
        for (int i = 0; i < v.n; i++) begin
            #1;
            chk("vec_valid", out_valid, 1);
            chk("vec_bit",   out_bit,   v.exp[W-1-i]);
            chk("vec_first", out_first, i == 0);
            chk("vec_last",  out_last,  i == v.n - 1);
            chk("vec_rdy",   in_ready,  i == v.n - 1);
            tick;
        end
        #1;
        chk("vec_end_valid", out_valid, 0);
        chk("vec_end_busy",  busy,      0);
    endtask

    initial begin
        logic [4:0] seq_b2b;
        int accepted;
        int done;
        int cyc;
        int rem;
        int eff;

        vecs[0] = '{16'h0005, 5'd3,  3,  16'hA000};
        vecs[1] = '{16'hA000, 5'd0,  16, 16'hA000};
        vecs[2] = '{16'h0001, 5'd1,  1,  16'h8000};
        vecs[3] = '{16'h8001, 5'd17, 16, 16'h8001};
        vecs[4] = '{16'h00F0, 5'd8,  8,  16'hF000};
        vecs[5] = '{16'h1234, 5'd16, 16, 16'h1234};
        vecs[6] = '{16'hFFFF, 5'd5,  5,  16'hF800};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        repeat (3) tick;
        chk_all_zero("rst");
        rst = 1'b0;
        #1;
        chk("rel_rdy", in_ready, 1);

        for (int k = 0; k < 7; k++) send_vec(vecs[k]);

        // Stall on bit 2 of 4'b1100
        in_valid = 1'b1; in_data = 16'h000C; in_len = 5'd4; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        #1;
        chk("st_b1", out_bit, 1);
        chk("st_f1", out_first, 1);
        tick;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_hold_bit",   out_bit,   1);
            chk("st_hold_first", out_first, 0);
            chk("st_hold_last",  out_last,  0);
            chk("st_hold_rdy",   in_ready,  0);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("st_b2", out_bit, 1);
        tick;
        chk("st_b3", out_bit, 0);
        chk("st_l3", out_last, 0);
        tick;
        chk("st_b4", out_bit, 0);
        chk("st_l4", out_last, 1);
        tick;
        chk("st_end", out_valid, 0);

        // Back-to-back 3'b110 then 3'b011
        seq_b2b = 5'b0;
        in_valid = 1'b1; in_data = 16'h0006; in_len = 5'd3; out_ready = 1'b1;
        tick;
        in_data = 16'h0003;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("bb_valid", out_valid, 1);
            chk("bb_bit",   out_bit,   (k == 0 || k == 1 || k == 4 || k == 5));
            chk("bb_first", out_first, (k == 0 || k == 3));
            chk("bb_last",  out_last,  (k == 2 || k == 5));
            chk("bb_rdy",   in_ready,  (k == 2 || k == 5));
            tick;
            if (k == 2) in_valid = 1'b0;
        end
        chk("bb_end", out_valid, 0);

        // Reset mid-word after two bits
        in_valid = 1'b1; in_data = 16'hFFFF; in_len = 5'd16; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk_all_zero("mrst_a");
        tick;
        chk_all_zero("mrst_b");
        rst = 1'b0;
        #1;
        chk("mrst_rel_rdy", in_ready, 1);
        send_vec(vecs[2]);

        // Randomized run with mod-5 checker on the serial output
        accepted = 0;
        done     = 0;
        cyc      = 0;
        rem      = 0;
        while ((accepted < 200 || q.size() != 0) && cyc < 20000) begin
            in_valid  = (accepted < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_len    = 5'($urandom_range(0, 20));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("r_valid", out_valid, q.size() != 0);
            chk("r_rdy",   in_ready,  (q.size() == 0) || (q.size() == 1 && out_ready));
            if (out_valid && q.size() != 0) begin
                chk("r_bit",   out_bit,   q[0].b);
                chk("r_first", out_first, q[0].f);
                chk("r_last",  out_last,  q[0].l);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                rem = out_first ? int'(out_bit) : (rem * 2 + int'(out_bit)) % 5;
                if (out_last) begin
                    chk("r_mod5", rem == 0, wq[0] % 5 == 0);
                    void'(wq.pop_front());
                    done++;
                end
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                eff = (in_len == 0 || in_len > 16) ? 16 : int'(in_len);
                for (int i = eff - 1; i >= 0; i--)
                    q.push_back('{in_data[i], i == eff - 1, i == 0});
                wq.push_back(int'(in_data) & ((1 << eff) - 1));
                accepted++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 20000) begin
            total++;
            bad++;
            $display("FAIL r_timeout actual=%0d words required=200", done);
        end
        chk("r_words", done, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
